// File: rtl/max6675_pkg.sv
// Shared MAX6675 frame layout and responder state encoding; also used by the reader side.
package max6675_pkg;

    localparam int MAX6675_FRAME_BITS  = 16;
    localparam int MAX6675_TEMP_BITS   = 12;
    localparam int MAX6675_RESULT_BITS = MAX6675_TEMP_BITS + 1;

    localparam int MAX6675_DUMMY_BIT    = 15;
    localparam int MAX6675_TEMP_MSB     = 14;
    localparam int MAX6675_TEMP_LSB     = 3;
    localparam int MAX6675_OPEN_BIT     = 2;
    localparam int MAX6675_DEV_ID_BIT   = 1;
    localparam int MAX6675_STATE_BIT    = 0;

    typedef enum logic [1:0] {
        CONVERT,
        READY,
        SHIFT
    } state_t;

    // result = {temperature, open flag}; dummy, device ID and state bits are always 0
    function automatic logic [MAX6675_FRAME_BITS-1:0] make_frame(
        input logic [MAX6675_RESULT_BITS-1:0] result
    );
        return {1'b0, result, 2'b00};
    endfunction

endpackage

// File: rtl/max6675_responder_sync_edge.sv
// N-stage synchroniser for an asynchronous pin followed by a one-flop edge detector.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic              level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/max6675_responder.sv
// MAX6675 SPI-slave emulation: timed conversion, then a 16-bit frame shifted out on miso.
module max6675_responder
    import max6675_pkg::*;
#(
    parameter int CONV_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] temp_in,
    input  logic        open_tc,
    input  logic        sel,
    input  logic        sclk,
    output logic        miso,
    output logic        miso_oe,
    output logic        busy,
    output logic        frame_done
);

    localparam int               CNT_W      = $clog2(CONV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CONV_CYCLES - 1);

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [MAX6675_RESULT_BITS-1:0]  result;
    logic [MAX6675_RESULT_BITS-1:0]  sample;
    logic [MAX6675_FRAME_BITS-1:0]   shreg;
    logic [4:0]                      bit_cnt;
    logic                            sel_rise;
    logic                            sel_fall;
    logic                            sclk_rise;
    logic                            sclk_fall;

    // sel idles high, so its synchroniser resets high to avoid a false fall after reset
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sel_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sel),
        .rise (sel_rise),
        .fall (sel_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign sample = {temp_in, open_tc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CONVERT;
            cnt        <= CNT_RELOAD;
            result     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            miso_oe    <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                CONVERT: begin
                    if (sel_fall) begin
                        state   <= SHIFT;
                        busy    <= 1'b0;
                        miso_oe <= 1'b1;
                        bit_cnt <= '0;
                        // a read landing on the completing clk still gets the fresh result
                        if (cnt == '0) begin
                            result <= sample;
                            shreg  <= make_frame(sample);
                        end else begin
                            shreg  <= make_frame(result);
                        end
                    end else if (cnt == '0) begin
                        result <= sample;
                        state  <= READY;
                        busy   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READY: begin
                    if (sel_fall) begin
                        state   <= SHIFT;
                        miso_oe <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= make_frame(result);
                    end
                end
                SHIFT: begin
                    if (sel_rise) begin
                        state      <= CONVERT;
                        busy       <= 1'b1;
                        miso_oe    <= 1'b0;
                        shreg      <= '0;
                        frame_done <= (bit_cnt == 5'd16);
                        cnt        <= CNT_RELOAD;
                    end else if (sclk_rise) begin
                        if (bit_cnt != 5'd17)
                            bit_cnt <= bit_cnt + 5'd1;
                    end else if (sclk_fall) begin
                        shreg <= {shreg[MAX6675_FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: begin
                    state <= CONVERT;
                    cnt   <= CNT_RELOAD;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign miso = miso_oe & shreg[MAX6675_FRAME_BITS-1];

endmodule
